led_rate_monitor: RTL and testbench

Measurement block that observes the randomised LED output and checks its on-rate against the programmed probability. On a start pulse it samples `led` over a fixed window of enabled cycles, counts hits, computes the expected hit count as WINDOW / probability with a sequential divider, and flags whether the measured count is within tolerance. It sits beside the LED randomiser as its on-chip checker: the randomiser writes the LED, this block reads and grades it.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_rate_monitor_seq_divider.sv | 81 ++++++++
 rtl/led_rate_monitor.sv | 137 +++++++++++++
 tb/tb_led_rate_monitor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED randomiser and its rate monitor.
//   PROB_W  : width of the probability code (on-rate = 1/probability)
//   state_t : rate-monitor FSM states
package led_pkg;

    localparam int PROB_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/led_rate_monitor_seq_divider.sv
// seq_divider: restoring divider producing one quotient bit per cycle,
// MSB first, W iterations after a start pulse.  The divisor is captured
// when start is seen, so later input changes do not disturb a division.
// A zero divisor skips the arithmetic and returns an all-ones quotient.
//   clk, rst_n : clock, async active-low reset
//   start      : load dividend/divisor and begin
//   dividend   : W-bit numerator
//   divisor    : W-bit denominator
//   quotient   : result, valid from the valid pulse until the next start
//   valid      : one-cycle pulse when the quotient is complete
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         valid
);

    localparam int IW = $clog2(W + 1);

    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_div;
    logic [IW-1:0] r_iter;
    logic          r_active;
    logic          r_div_zero;
    logic          r_valid;

    logic [W:0]    w_shift;
    logic [W:0]    w_trial;

    // Bring the next dividend bit into the partial remainder and try to
    // subtract; the remainder is always below the divisor, so W bits hold it.
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_trial = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_iter     <= '0;
            r_active   <= 1'b0;
            r_div_zero <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (start) begin
                r_rem      <= '0;
                r_quo      <= dividend;
                r_div      <= divisor;
                r_iter     <= IW'(W);
                r_active   <= 1'b1;
                r_div_zero <= (divisor == '0);
            end else if (r_active) begin
                if (!r_div_zero) begin
                    if (!w_trial[W]) begin
                        r_rem <= w_trial[W-1:0];
                        r_quo <= {r_quo[W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[W-1:0];
                        r_quo <= {r_quo[W-2:0], 1'b0};
                    end
                end
                r_iter <= r_iter - 1'b1;
                if (r_iter == IW'(1)) begin
                    r_active <= 1'b0;
                    r_valid  <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_div_zero ? '1 : r_quo;
    assign valid    = r_valid;

endmodule

// File: rtl/led_rate_monitor.sv
// led_rate_monitor: grades the randomised LED on-rate.  On start it counts
// led-high samples over WINDOW enabled cycles, divides WINDOW by the latched
// probability code and flags whether the hit count is within TOL of it.
//   clk, rst_n     : clock, async active-low reset
//   start          : single-cycle measurement request (ignored when busy)
//   enable         : randomiser enable; only enabled cycles are samples
//   led            : randomiser output under test
//   probability    : probability code, latched at start
//   busy           : measurement in progress
//   done           : one-cycle pulse when results update
//   hit_count      : led-high samples in the last window
//   expected_count : floor(WINDOW / probability), all ones for probability 0
//   in_range       : |hit_count - expected_count| <= TOL
//
// state  | meaning
// IDLE   | waiting for start; results hold
// SAMPLE | counting enabled samples and hits
// DIVIDE | sequential divider computing WINDOW / prob_q
// DONE   | results registered, done pulsed; busy drops next cycle
module led_rate_monitor
    import led_pkg::*;
#(
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 16,
    parameter int TOL    = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              enable,
    input  logic              led,
    input  logic [PROB_W-1:0] probability,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  expected_count,
    output logic              in_range
);

    state_t            r_state;
    logic [PROB_W-1:0] r_prob_q;
    logic [CNT_W-1:0]  r_sample_cnt;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_hit_count;
    logic [CNT_W-1:0]  r_expected_count;
    logic              r_in_range;

    logic              w_last_sample;
    logic [CNT_W-1:0]  w_quotient;
    logic              w_div_valid;
    logic [CNT_W:0]    w_diff;
    logic [CNT_W:0]    w_abs;
    logic              w_in_tol;

    // The divider starts on the same edge the final sample is taken, so the
    // quotient is ready CNT_W edges later and DONE follows one edge after.
    assign w_last_sample = (r_state == SAMPLE) && enable &&
                           (r_sample_cnt == CNT_W'(WINDOW - 1));

    seq_divider #(
        .W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_last_sample),
        .dividend (CNT_W'(WINDOW)),
        .divisor  ({{(CNT_W-PROB_W){1'b0}}, r_prob_q}),
        .quotient (w_quotient),
        .valid    (w_div_valid)
    );

    // Extra sign bit keeps the difference exact for any pair of counts.
    assign w_diff   = {1'b0, r_hit_cnt} - {1'b0, w_quotient};
    assign w_abs    = w_diff[CNT_W] ? (~w_diff + 1'b1) : w_diff;
    assign w_in_tol = (w_abs <= (CNT_W+1)'(TOL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_prob_q         <= '0;
            r_sample_cnt     <= '0;
            r_hit_cnt        <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_hit_count      <= '0;
            r_expected_count <= '0;
            r_in_range       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_prob_q     <= probability;
                        r_sample_cnt <= '0;
                        r_hit_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (enable) begin
                        r_sample_cnt <= r_sample_cnt + 1'b1;
                        r_hit_cnt    <= r_hit_cnt + {{(CNT_W-1){1'b0}}, led};
                        if (w_last_sample) begin
                            r_state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (w_div_valid) begin
                        r_hit_count      <= r_hit_cnt;
                        r_expected_count <= w_quotient;
                        r_in_range       <= (r_prob_q != '0) && w_in_tol;
                        r_done           <= 1'b1;
                        r_state          <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign hit_count      = r_hit_count;
    assign expected_count = r_expected_count;
    assign in_range       = r_in_range;

endmodule

// File: tb/tb_led_rate_monitor.sv
// Bench for led_rate_monitor: expected results are queued when a
// measurement is launched and compared when done pulses.
module tb_led_rate_monitor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        enable;
    logic        led;
    logic [6:0]  probability;
    logic        busy;
    logic        done;
    logic [15:0] hit_count;
    logic [15:0] expected_count;
    logic        in_range;

    typedef struct {
        logic [15:0] hit;
        logic [15:0] expc;
        logic        inr;
        int          lat_min;
        int          lat_max;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errs   = 0;
    int n_done   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int mode     = 4;
    int k_lim    = 0;

    led_rate_monitor #(
        .WINDOW (1000),
        .CNT_W  (16),
        .TOL    (50)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .enable         (enable),
        .led            (led),
        .probability    (probability),
        .busy           (busy),
        .done           (done),
        .hit_count      (hit_count),
        .expected_count (expected_count),
        .in_range       (in_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // led/enable pattern generator, updated well after the active edge
    always @(posedge clk) begin
        #2;
        case (mode)
            0: begin enable = 1'b1; led = 1'b1; end
            1: begin enable = 1'b1; led = ~led; end
            2: begin enable = ~enable; led = enable; end
            3: begin enable = 1'b1; led = 1'b0; end
            5: begin enable = 1'b1; led = ((cyc - t_start) < k_lim); end
            default: begin enable = 1'b0; led = 1'b0; end
        endcase
    end

    // scoreboard: compare on each done pulse
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (rst_n && done) begin
            check_val("sb_pending_at_done", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e   = sb_q.pop_front();
                lat = cyc - t_start;
                check_val("hit_count", hit_count, e.hit);
                check_val("expected_count", expected_count, e.expc);
                check_val("in_range", in_range, e.inr);
                check_val("latency_in_bounds", (lat >= e.lat_min) && (lat <= e.lat_max), 1);
            end
            n_done++;
        end
    end

    task automatic begin_meas(input logic [6:0] prob, input int md, input logic [15:0] h,
                              input logic [15:0] x, input logic inr, input int lmin, input int lmax);
        exp_t e;
        e.hit = h; e.expc = x; e.inr = inr; e.lat_min = lmin; e.lat_max = lmax;
        sb_q.push_back(e);
        @(posedge clk); #1;
        probability = prob;
        mode        = md;
        start       = 1'b1;
        @(posedge clk); #1;
        t_start = cyc;
        start   = 1'b0;
        check_val("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (n_done < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n_done < target) check_val("done_timeout", n_done, target);
        repeat (2) @(posedge clk);
        #1;
        check_val("busy_after_done", busy, 0);
        check_val("done_is_pulse", done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; enable = 1'b0; led = 1'b0; probability = 7'd0;
        #23;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_hit", hit_count, 0);
        check_val("rst_expected", expected_count, 0);
        check_val("rst_in_range", in_range, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // steady led: full hit count, out of tolerance
        begin_meas(7'd4, 0, 16'd1000, 16'd250, 1'b0, 1017, 1017);
        wait_done(1, 1300);
        check_val("hit_hold_idle", hit_count, 1000);

        // alternating led, probability change mid-window ignored
        begin_meas(7'd2, 1, 16'd500, 16'd500, 1'b1, 1017, 1017);
        repeat (400) @(posedge clk);
        #1 probability = 7'd3;
        wait_done(2, 1300);

        // enable toggling, led=enable; repeated start while busy ignored
        begin_meas(7'd5, 2, 16'd1000, 16'd200, 1'b0, 2016, 2017);
        repeat (5) @(posedge clk);
        #1 check_val("hit_hold_after_start", hit_count, 500);
        repeat (500) @(posedge clk);
        #1 start = 1'b1; probability = 7'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(3, 2500);
        repeat (1200) @(posedge clk);
        #1 check_val("no_extra_done", n_done, 3);

        // divide by zero
        begin_meas(7'd0, 3, 16'd0, 16'hFFFF, 1'b0, 1017, 1017);
        wait_done(4, 1300);

        // tolerance boundary: diff exactly TOL, then TOL+1
        k_lim = 550;
        begin_meas(7'd2, 5, 16'd550, 16'd500, 1'b1, 1017, 1017);
        wait_done(5, 1300);
        k_lim = 449;
        begin_meas(7'd2, 5, 16'd449, 16'd500, 1'b0, 1017, 1017);
        wait_done(6, 1300);

        // asynchronous reset mid-window, then a clean full run
        begin_meas(7'd4, 0, 16'd1000, 16'd250, 1'b0, 1017, 1017);
        repeat (300) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_hit", hit_count, 0);
        check_val("midrst_expected", expected_count, 0);
        check_val("midrst_in_range", in_range, 0);
        sb_q.delete();
        mode = 4;
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin_meas(7'd4, 0, 16'd1000, 16'd250, 1'b0, 1017, 1017);
        wait_done(7, 1300);

        check_val("sb_empty_at_end", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
